victim_cache_store: RTL
=======================

// Module: victim_cache_store
// PURPOSE
//  Parametrised, fully associative victim cache store. Holds lines evicted from L1 with tag, valid, dirty and LRU age.
//  Sits between the L1 cache and the memory/L2 port. Supports three operations:
//    - insert a victim line;
//    - look up a missing L1 tag (swap-out on take);
//    - write back a dirty line displaced by an insert.
//  Generalises the fixed 4-way victim data array to N entries, with tag match, replacement and a writeback handshake.
// PARAMETERS
//  ENTRIES  4    number of lines held; >=2
//  LINE_W   128  line width in bits (lc3b_burst)
//  TAG_W    12   tag width in bits (16-bit address, 16-byte line)
// PORTS
//  clk            in   1        clock; all state updates on posedge
//  rst_n          in   1        synchronous reset, active low
//  ins_valid      in   1        insert request
//  ins_ready      out  1        store can accept an insert this cycle
//  ins_tag        in   TAG_W    tag of inserted line
//  ins_data       in   LINE_W   inserted line
//  ins_dirty      in   1        inserted line is dirty
//  lk_valid       in   1        lookup request (always accepted)
//  lk_take        in   1        on hit, invalidate entry (line moves to L1)
//  lk_tag         in   TAG_W    lookup tag
//  lk_resp_valid  out  1        lookup response valid
//  lk_hit         out  1        response: tag matched a valid entry
//  lk_data        out  LINE_W   response: hit line; 0 on miss
//  lk_dirty       out  1        response: hit line dirty bit
//  wb_valid       out  1        dirty victim awaiting writeback
//  wb_ready       in   1        memory accepts writeback
//  wb_tag         out  TAG_W    writeback tag
//  wb_data        out  LINE_W   writeback line
//  occupancy      out  $clog2(ENTRIES+1)  count of valid entries
// BEHAVIOUR
//  Reset (rst_n=0 at posedge)
//    - All entries invalid; data, tags and dirty bits cleared.
//    - age[i]=i; state=IDLE.
//    - All outputs 0, including ins_ready. ins_ready=1 from the first cycle after reset.
//    - Reset during WB_WAIT drops the pending writeback.
//  FSM: IDLE -> WB_WAIT on an accepted insert that displaces a valid dirty entry.
//       WB_WAIT -> IDLE on wb_valid&wb_ready. ins_ready = (state==IDLE).
//  Insert (ins_valid&ins_ready), completes in one edge:
//    - Target selection, in priority order:
//        (1) valid entry with tag==ins_tag: overwrite, dirty = old|ins_dirty, no writeback;
//        (2) lowest-index invalid entry;
//        (3) LRU valid entry = max age.
//    - In case (3), if the victim is dirty: its tag/data are captured into the wb regs on the same edge,
//      wb_valid=1 next cycle, FSM -> WB_WAIT. A clean victim is silently dropped.
//    - The target becomes MRU. The new line is visible to lookups from the next cycle.
//  Lookup, 1-cycle latency:
//    - lk_resp_valid/lk_hit/lk_data/lk_dirty are registered and reflect pre-edge contents.
//    - lk_resp_valid is 0 in cycles without lk_valid; lk_data=0 on miss.
//    - Hit with lk_take=0: entry becomes MRU.
//    - Hit with lk_take=1: entry invalidated; its age is left unchanged.
//    - Lookups are also served during WB_WAIT.
//  Age update (touch of entry t): entries with age<age[t] increment; age[t]=0. Ages stay a permutation of 0..ENTRIES-1.
//  Simultaneous events:
//    - Lookup sees pre-edge state. Same tag inserted and looked up in one cycle: response reflects the old contents.
//    - If take and insert hit the same entry: insert wins (entry valid, new data, MRU).
//    - An entry freed by take is not an invalid target for an insert in the same cycle; it is usable next cycle.
//    - Insert-touch and lookup-touch in the same cycle: insert touch applied last (insert target is MRU).
//  occupancy: registered count of valid bits, updated with entries. It never exceeds ENTRIES.
//  wb_tag/wb_data hold stable while wb_valid=1.
// TESTING
//  1. Reset, then insert tags 1..4 (ENTRIES=4): occupancy=4, no wb_valid; lookup tag 3 -> next cycle hit=1, lk_data=line3.
//  2. Full, all dirty; touch tag 1 via lookup (take=0); insert tag 5 -> wb_valid with wb_tag=2, ins_ready=0.
//     Hold wb_ready=0 for 3 cycles: outputs stable. Then wb_ready=1 -> ins_ready=1.
//  3. Full, tag 2 clean and LRU; insert tag 6 -> no writeback; lookup tag 2 misses, lk_data=0.
//  4. Lookup tag 4 with take=1 -> hit, occupancy 4->3. Insert tag 7 the next cycle -> lands in the freed slot, no eviction.
//  5. Same cycle: lookup(take) tag 3 and insert tag 3 with new data -> response shows old data;
//     next lookup shows new data; occupancy unchanged.
//  6. Assert rst_n=0 while in WB_WAIT -> next cycle wb_valid=0, occupancy=0, all lookups miss.

Source files
------------

// File: rtl/victim_cache_store.sv
// Fully associative victim store: holds lines evicted from L1 and serves tag lookups with a
// 1-cycle registered response. A dirty line displaced by an insert is queued for writeback.
module victim_cache_store #(
  parameter int ENTRIES = 4,
  parameter int LINE_W  = 128,
  parameter int TAG_W   = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ins_valid,
  output logic                           ins_ready,
  input  logic [TAG_W-1:0]               ins_tag,
  input  logic [LINE_W-1:0]              ins_data,
  input  logic                           ins_dirty,
  input  logic                           lk_valid,
  input  logic                           lk_take,
  input  logic [TAG_W-1:0]               lk_tag,
  output logic                           lk_resp_valid,
  output logic                           lk_hit,
  output logic [LINE_W-1:0]              lk_data,
  output logic                           lk_dirty,
  output logic                           wb_valid,
  input  logic                           wb_ready,
  output logic [TAG_W-1:0]               wb_tag,
  output logic [LINE_W-1:0]              wb_data,
  output logic [$clog2(ENTRIES+1)-1:0]   occupancy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = $clog2(ENTRIES+1);
  localparam logic [IDX_W-1:0] AGE_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(ENTRIES-1);

  typedef enum logic {IDLE = 1'b0, WB_WAIT = 1'b1} state_t;
  typedef logic [ENTRIES-1:0][IDX_W-1:0] ages_t;

  state_t              state_q, state_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [ENTRIES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_d  [ENTRIES];
  logic [LINE_W-1:0]   data_q [ENTRIES];
  logic [LINE_W-1:0]   data_d [ENTRIES];
  ages_t               age_q, age_mid, age_d;
  logic [OCC_W-1:0]    occ_q, occ_d;

  logic                ins_ready_q;
  logic                lk_resp_valid_q, lk_hit_q, lk_dirty_q;
  logic [LINE_W-1:0]   lk_data_q;
  logic                wb_valid_q;
  logic [TAG_W-1:0]    wb_tag_q;
  logic [LINE_W-1:0]   wb_data_q;

  logic [ENTRIES-1:0]  lk_match, ins_match, lru_vec;
  logic [IDX_W-1:0]    lk_idx, ins_idx, free_idx, lru_idx, tgt_idx;
  logic                ins_fire, lk_hit_any, lk_touch, lk_free;
  logic                ins_hit_any, any_free, evict;

  function automatic logic [IDX_W-1:0] lowest(input logic [ENTRIES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Make entry t MRU: everything younger than it ages by one, keeping ages a permutation.
  function automatic ages_t touch(input ages_t a, input logic [IDX_W-1:0] t);
    ages_t r;
    r = a;
    for (int i = 0; i < ENTRIES; i++) begin
      if (a[i] < a[t]) r[i] = a[i] + AGE_ONE;
    end
    r[t] = '0;
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
      assign lk_match[gi]  = valid_q[gi] && (tag_q[gi] == lk_tag);
      assign ins_match[gi] = valid_q[gi] && (tag_q[gi] == ins_tag);
      assign lru_vec[gi]   = (age_q[gi] == AGE_MAX);
    end
  endgenerate

  always_comb begin
    lk_idx      = lowest(lk_match);
    ins_idx     = lowest(ins_match);
    free_idx    = lowest(~valid_q);
    lru_idx     = lowest(lru_vec);
    ins_fire    = ins_valid && ins_ready_q;
    lk_hit_any  = |lk_match;
    lk_touch    = lk_valid && lk_hit_any && !lk_take;
    lk_free     = lk_valid && lk_hit_any && lk_take;
    ins_hit_any = |ins_match;
    any_free    = ~&valid_q;

    if (ins_hit_any)   tgt_idx = ins_idx;
    else if (any_free) tgt_idx = free_idx;
    else               tgt_idx = lru_idx;

    // A victim taken by L1 in the same cycle now lives in L1, so it needs no writeback.
    evict = ins_fire && !ins_hit_any && !any_free && dirty_q[lru_idx]
            && !(lk_free && (lk_idx == lru_idx));

    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;

    age_mid = lk_touch ? touch(age_q, lk_idx) : age_q;
    age_d   = ins_fire ? touch(age_mid, tgt_idx) : age_mid;

    if (lk_free) begin
      valid_d[lk_idx] = 1'b0;
      dirty_d[lk_idx] = 1'b0;
    end
    if (ins_fire) begin
      valid_d[tgt_idx] = 1'b1;
      tag_d[tgt_idx]   = ins_tag;
      data_d[tgt_idx]  = ins_data;
      dirty_d[tgt_idx] = ins_dirty | (ins_hit_any & dirty_q[tgt_idx]);
    end

    occ_d = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end

    state_d = state_q;
    case (state_q)
      IDLE:    if (evict) state_d = WB_WAIT;
      WB_WAIT: if (wb_valid_q && wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      dirty_q         <= '0;
      occ_q           <= '0;
      ins_ready_q     <= 1'b0;
      lk_resp_valid_q <= 1'b0;
      lk_hit_q        <= 1'b0;
      lk_data_q       <= '0;
      lk_dirty_q      <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_tag_q        <= '0;
      wb_data_q       <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
        age_q[i]  <= IDX_W'(i);
      end
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      age_q       <= age_d;
      occ_q       <= occ_d;
      ins_ready_q <= (state_d == IDLE);

      lk_resp_valid_q <= lk_valid;
      lk_hit_q        <= lk_valid && lk_hit_any;
      lk_data_q       <= (lk_valid && lk_hit_any) ? data_q[lk_idx] : '0;
      lk_dirty_q      <= lk_valid && lk_hit_any && dirty_q[lk_idx];

      if (evict) begin
        wb_valid_q <= 1'b1;
        wb_tag_q   <= tag_q[lru_idx];
        wb_data_q  <= data_q[lru_idx];
      end else if (wb_valid_q && wb_ready) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign ins_ready     = ins_ready_q;
  assign lk_resp_valid = lk_resp_valid_q;
  assign lk_hit        = lk_hit_q;
  assign lk_data       = lk_data_q;
  assign lk_dirty      = lk_dirty_q;
  assign wb_valid      = wb_valid_q;
  assign wb_tag        = wb_tag_q;
  assign wb_data       = wb_data_q;
  assign occupancy     = occ_q;

endmodule
